// File: rtl/axi_riscv_lrsc_resv_ctrl.sv
// LR/SC reservation-table controller: tracks per-ID granule reservations,
// invalidates them on snooped writes and issues registered SC verdicts.
module axi_riscv_lrsc_resv_ctrl #(
    parameter int AXI_ADDR_WIDTH = 64,
    parameter int AXI_ID_WIDTH   = 4,
    parameter int NUM_RESV       = 4,
    parameter int GRAN_LOG2      = 3,
    parameter int CNT_W          = $clog2(NUM_RESV + 1)
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      lr_valid_i,
    output logic                      lr_ready_o,
    input  logic [AXI_ID_WIDTH-1:0]   lr_id_i,
    input  logic [AXI_ADDR_WIDTH-1:0] lr_addr_i,
    input  logic                      sc_valid_i,
    output logic                      sc_ready_o,
    input  logic [AXI_ID_WIDTH-1:0]   sc_id_i,
    input  logic [AXI_ADDR_WIDTH-1:0] sc_addr_i,
    output logic                      sc_resp_valid_o,
    input  logic                      sc_resp_ready_i,
    output logic                      sc_ok_o,
    input  logic                      wr_valid_i,
    input  logic [AXI_ADDR_WIDTH-1:0] wr_addr_i,
    output logic [CNT_W-1:0]          resv_cnt_o
);

    localparam int GW = AXI_ADDR_WIDTH - GRAN_LOG2;
    localparam int IW = (NUM_RESV > 1) ? $clog2(NUM_RESV) : 1;

    typedef enum logic {
        IDLE,
        RESP
    } state_t;

    state_t                    r_state;
    logic                      r_respValid;
    logic                      r_ok;
    logic [CNT_W-1:0]          r_cnt;
    logic [IW-1:0]             r_victim;
    logic [NUM_RESV-1:0]       r_valid;
    logic [AXI_ID_WIDTH-1:0]   r_id   [NUM_RESV];
    logic [GW-1:0]             r_gran [NUM_RESV];

    logic                      w_lrHs;
    logic                      w_scHs;
    logic                      w_scOk;
    logic [GW-1:0]             w_lrGran;
    logic [GW-1:0]             w_scGran;
    logic [GW-1:0]             w_wrGran;
    logic [NUM_RESV-1:0]       w_valid;
    logic [AXI_ID_WIDTH-1:0]   w_id   [NUM_RESV];
    logic [GW-1:0]             w_gran [NUM_RESV];
    logic [IW-1:0]             w_victim;
    logic                      w_hit;
    logic [IW-1:0]             w_hitIdx;
    logic                      w_free;
    logic [IW-1:0]             w_freeIdx;
    logic [IW-1:0]             w_allocIdx;
    logic [CNT_W-1:0]          w_cnt;
    logic                      w_unusedAddrBits;

    assign w_lrGran = lr_addr_i[AXI_ADDR_WIDTH-1:GRAN_LOG2];
    assign w_scGran = sc_addr_i[AXI_ADDR_WIDTH-1:GRAN_LOG2];
    assign w_wrGran = wr_addr_i[AXI_ADDR_WIDTH-1:GRAN_LOG2];
    assign w_unusedAddrBits = ^{lr_addr_i[GRAN_LOG2-1:0], sc_addr_i[GRAN_LOG2-1:0],
                                wr_addr_i[GRAN_LOG2-1:0]};

    assign lr_ready_o      = (r_state == IDLE);
    assign sc_ready_o      = (r_state == IDLE);
    assign w_lrHs          = lr_valid_i && (r_state == IDLE);
    assign w_scHs          = sc_valid_i && (r_state == IDLE);
    assign sc_resp_valid_o = r_respValid;
    assign sc_ok_o         = r_ok;
    assign resv_cnt_o      = r_cnt;

    // Next table state: snoop invalidation, then SC check/invalidate, then LR allocation
    always_comb begin
        w_valid    = r_valid;
        w_id       = r_id;
        w_gran     = r_gran;
        w_victim   = r_victim;
        w_scOk     = 1'b0;
        w_hit      = 1'b0;
        w_hitIdx   = '0;
        w_free     = 1'b0;
        w_freeIdx  = '0;
        w_allocIdx = '0;
        w_cnt      = '0;

        if (wr_valid_i) begin
            for (int i = 0; i < NUM_RESV; i++) begin
                if (r_gran[i] == w_wrGran) w_valid[i] = 1'b0;
            end
        end

        if (w_scHs) begin
            for (int i = 0; i < NUM_RESV; i++) begin
                if (w_valid[i] && r_id[i] == sc_id_i && r_gran[i] == w_scGran) w_scOk = 1'b1;
            end
            // A successful SC also kills other harts' reservations on that granule
            for (int i = 0; i < NUM_RESV; i++) begin
                if (r_id[i] == sc_id_i || (w_scOk && r_gran[i] == w_scGran)) w_valid[i] = 1'b0;
            end
        end

        if (w_lrHs) begin
            for (int i = 0; i < NUM_RESV; i++) begin
                if (!w_hit && w_valid[i] && r_id[i] == lr_id_i) begin
                    w_hit    = 1'b1;
                    w_hitIdx = IW'(i);
                end
                if (!w_free && !w_valid[i]) begin
                    w_free    = 1'b1;
                    w_freeIdx = IW'(i);
                end
            end
            if (w_hit) begin
                w_allocIdx = w_hitIdx;
            end else if (w_free) begin
                w_allocIdx = w_freeIdx;
            end else begin
                w_allocIdx = r_victim;
                w_victim   = (r_victim == IW'(NUM_RESV - 1)) ? '0 : r_victim + 1'b1;
            end
            w_valid[w_allocIdx] = 1'b1;
            w_id[w_allocIdx]    = lr_id_i;
            w_gran[w_allocIdx]  = w_lrGran;
        end

        for (int i = 0; i < NUM_RESV; i++) begin
            w_cnt = w_cnt + CNT_W'(w_valid[i]);
        end
    end

    // Table, count and verdict registers; FSM holds the verdict until consumed
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= IDLE;
            r_respValid <= 1'b0;
            r_ok        <= 1'b0;
            r_cnt       <= '0;
            r_victim    <= '0;
            r_valid     <= '0;
            for (int i = 0; i < NUM_RESV; i++) begin
                r_id[i]   <= '0;
                r_gran[i] <= '0;
            end
        end else begin
            r_valid  <= w_valid;
            r_id     <= w_id;
            r_gran   <= w_gran;
            r_victim <= w_victim;
            r_cnt    <= w_cnt;
            case (r_state)
                IDLE: begin
                    if (w_scHs) begin
                        r_state     <= RESP;
                        r_respValid <= 1'b1;
                        r_ok        <= w_scOk;
                    end
                end
                RESP: begin
                    if (sc_resp_ready_i) begin
                        r_state     <= IDLE;
                        r_respValid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_respValid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_riscv_lrsc_resv_ctrl.sv
// Self-checking bench for the LR/SC reservation controller: directed plan
// followed by random traffic, compared against a rule-level table model.
module tb_axi_riscv_lrsc_resv_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        lr_valid_i;
    logic        lr_ready_o;
    logic [3:0]  lr_id_i;
    logic [63:0] lr_addr_i;
    logic        sc_valid_i;
    logic        sc_ready_o;
    logic [3:0]  sc_id_i;
    logic [63:0] sc_addr_i;
    logic        sc_resp_valid_o;
    logic        sc_resp_ready_i;
    logic        sc_ok_o;
    logic        wr_valid_i;
    logic [63:0] wr_addr_i;
    logic [2:0]  resv_cnt_o;

    int compared   = 0;
    int mismatched = 0;

    // Reference model: reservations as plain (valid, id, granule) records
    logic        mValid [4];
    logic [3:0]  mId    [4];
    logic [60:0] mGran  [4];
    int          mVictim;
    logic        mIdle;
    logic        mRespValid;
    logic        mOk;

    axi_riscv_lrsc_resv_ctrl dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .lr_valid_i     (lr_valid_i),
        .lr_ready_o     (lr_ready_o),
        .lr_id_i        (lr_id_i),
        .lr_addr_i      (lr_addr_i),
        .sc_valid_i     (sc_valid_i),
        .sc_ready_o     (sc_ready_o),
        .sc_id_i        (sc_id_i),
        .sc_addr_i      (sc_addr_i),
        .sc_resp_valid_o(sc_resp_valid_o),
        .sc_resp_ready_i(sc_resp_ready_i),
        .sc_ok_o        (sc_ok_o),
        .wr_valid_i     (wr_valid_i),
        .wr_addr_i      (wr_addr_i),
        .resv_cnt_o     (resv_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
            $error("[TB] %s differs from model", tag);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < 4; i++) begin
            mValid[i] = 1'b0;
            mId[i]    = '0;
            mGran[i]  = '0;
        end
        mVictim    = 0;
        mIdle      = 1'b1;
        mRespValid = 1'b0;
        mOk        = 1'b0;
    endtask

    function automatic int modelCount();
        int n = 0;
        for (int i = 0; i < 4; i++) n += int'(mValid[i]);
        return n;
    endfunction

    task automatic modelLr(input logic [3:0] id, input logic [63:0] addr);
        int slot = -1;
        for (int i = 0; i < 4; i++)
            if (slot < 0 && mValid[i] && mId[i] == id) slot = i;
        for (int i = 0; i < 4; i++)
            if (slot < 0 && !mValid[i]) slot = i;
        if (slot < 0) begin
            slot    = mVictim;
            mVictim = (mVictim + 1) % 4;
        end
        mValid[slot] = 1'b1;
        mId[slot]    = id;
        mGran[slot]  = addr[63:3];
    endtask

    // One clock of stimulus; the model applies snoop, then SC, then LR
    task automatic applyStimulus(input logic lrV, input logic [3:0] lrId, input logic [63:0] lrA,
                                 input logic scV, input logic [3:0] scId, input logic [63:0] scA,
                                 input logic wrV, input logic [63:0] wrA, input logic rdy);
        logic oldIdle;
        logic okNow;
        lr_valid_i      = lrV;
        lr_id_i         = lrId;
        lr_addr_i       = lrA;
        sc_valid_i      = scV;
        sc_id_i         = scId;
        sc_addr_i       = scA;
        wr_valid_i      = wrV;
        wr_addr_i       = wrA;
        sc_resp_ready_i = rdy;
        checkOutput("lr_ready", {63'd0, lr_ready_o}, {63'd0, mIdle});
        checkOutput("sc_ready", {63'd0, sc_ready_o}, {63'd0, mIdle});
        @(posedge clk_i);
        #1;
        oldIdle = mIdle;
        okNow   = 1'b0;
        if (wrV)
            for (int i = 0; i < 4; i++)
                if (mValid[i] && mGran[i] == wrA[63:3]) mValid[i] = 1'b0;
        if (oldIdle && scV) begin
            for (int i = 0; i < 4; i++)
                if (mValid[i] && mId[i] == scId && mGran[i] == scA[63:3]) okNow = 1'b1;
            for (int i = 0; i < 4; i++)
                if (mId[i] == scId || (okNow && mGran[i] == scA[63:3])) mValid[i] = 1'b0;
        end
        if (oldIdle && lrV) modelLr(lrId, lrA);
        if (oldIdle && scV) begin
            mIdle      = 1'b0;
            mRespValid = 1'b1;
            mOk        = okNow;
        end else if (!oldIdle && rdy) begin
            mIdle      = 1'b1;
            mRespValid = 1'b0;
        end
        checkOutput("resp_valid", {63'd0, sc_resp_valid_o}, {63'd0, mRespValid});
        checkOutput("sc_ok", {63'd0, sc_ok_o}, {63'd0, mOk});
        checkOutput("resv_cnt", {61'd0, resv_cnt_o}, 64'(modelCount()));
    endtask

    task automatic lrStep(input logic [3:0] id, input logic [63:0] a);
        applyStimulus(1'b1, id, a, 1'b0, 4'd0, 64'd0, 1'b0, 64'd0, 1'b1);
    endtask

    task automatic scStep(input logic [3:0] id, input logic [63:0] a, input logic rdy);
        applyStimulus(1'b0, 4'd0, 64'd0, 1'b1, id, a, 1'b0, 64'd0, rdy);
    endtask

    task automatic wrStep(input logic [63:0] a, input logic rdy);
        applyStimulus(1'b0, 4'd0, 64'd0, 1'b0, 4'd0, 64'd0, 1'b1, a, rdy);
    endtask

    task automatic idleStep(input logic rdy);
        applyStimulus(1'b0, 4'd0, 64'd0, 1'b0, 4'd0, 64'd0, 1'b0, 64'd0, rdy);
    endtask

    initial begin
        logic        rLrV, rScV, rWrV, rRdy;
        logic [3:0]  rLrId, rScId;
        logic [63:0] rLrA, rScA, rWrA;

        rst_ni          = 1'b0;
        lr_valid_i      = 1'b0;
        lr_id_i         = '0;
        lr_addr_i       = '0;
        sc_valid_i      = 1'b0;
        sc_id_i         = '0;
        sc_addr_i       = '0;
        wr_valid_i      = 1'b0;
        wr_addr_i       = '0;
        sc_resp_ready_i = 1'b1;
        modelReset();
        repeat (2) @(posedge clk_i);
        #1;
        checkOutput("rst_resp_valid", {63'd0, sc_resp_valid_o}, 64'd0);
        checkOutput("rst_ok", {63'd0, sc_ok_o}, 64'd0);
        checkOutput("rst_cnt", {61'd0, resv_cnt_o}, 64'd0);
        checkOutput("rst_lr_ready", {63'd0, lr_ready_o}, 64'd1);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        $display("[TB] basic LR/SC");
        lrStep(4'd2, 64'h1000);
        checkOutput("tp1_cnt1", {61'd0, resv_cnt_o}, 64'd1);
        scStep(4'd2, 64'h1004, 1'b1);
        checkOutput("tp1_valid", {63'd0, sc_resp_valid_o}, 64'd1);
        checkOutput("tp1_ok", {63'd0, sc_ok_o}, 64'd1);
        checkOutput("tp1_cnt0", {61'd0, resv_cnt_o}, 64'd0);
        idleStep(1'b1);

        $display("[TB] snoop granule boundary");
        lrStep(4'd1, 64'h2000);
        wrStep(64'h2007, 1'b1);
        scStep(4'd1, 64'h2000, 1'b1);
        checkOutput("tp2_ok_same_gran", {63'd0, sc_ok_o}, 64'd0);
        idleStep(1'b1);
        lrStep(4'd1, 64'h2000);
        wrStep(64'h2008, 1'b1);
        scStep(4'd1, 64'h2000, 1'b1);
        checkOutput("tp2_ok_next_gran", {63'd0, sc_ok_o}, 64'd1);
        idleStep(1'b1);

        $display("[TB] competing reservations");
        lrStep(4'd1, 64'h3000);
        lrStep(4'd3, 64'h3000);
        scStep(4'd1, 64'h3000, 1'b1);
        checkOutput("tp3_ok1", {63'd0, sc_ok_o}, 64'd1);
        idleStep(1'b1);
        scStep(4'd3, 64'h3000, 1'b1);
        checkOutput("tp3_ok3", {63'd0, sc_ok_o}, 64'd0);
        checkOutput("tp3_cnt", {61'd0, resv_cnt_o}, 64'd0);
        idleStep(1'b1);

        $display("[TB] victim replacement");
        for (int i = 0; i < 5; i++) lrStep(4'(i), 64'h7000 + 64'(i) * 64'h100);
        checkOutput("tp4_cnt_full", {61'd0, resv_cnt_o}, 64'd4);
        scStep(4'd0, 64'h7000, 1'b1);
        checkOutput("tp4_ok_id0", {63'd0, sc_ok_o}, 64'd0);
        checkOutput("tp4_cnt_after_sc0", {61'd0, resv_cnt_o}, 64'd4);
        idleStep(1'b1);
        scStep(4'd1, 64'h7100, 1'b1);
        checkOutput("tp4_ok_id1", {63'd0, sc_ok_o}, 64'd1);
        idleStep(1'b1);

        $display("[TB] backpressure with snoop in RESP");
        scStep(4'd2, 64'h7200, 1'b0);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) wrStep(64'h7300, 1'b0);
            else idleStep(1'b0);
            checkOutput("tp5_hold_valid", {63'd0, sc_resp_valid_o}, 64'd1);
            checkOutput("tp5_hold_ok", {63'd0, sc_ok_o}, 64'd1);
        end
        idleStep(1'b1);
        checkOutput("tp5_released", {63'd0, sc_resp_valid_o}, 64'd0);

        $display("[TB] same-cycle snoop and SC");
        lrStep(4'd0, 64'h4000);
        applyStimulus(1'b0, 4'd0, 64'd0, 1'b1, 4'd0, 64'h4000, 1'b1, 64'h4000, 1'b1);
        checkOutput("tp6_ok", {63'd0, sc_ok_o}, 64'd0);
        idleStep(1'b1);

        $display("[TB] random traffic");
        for (int n = 0; n < 400; n++) begin
            rLrV  = ($urandom_range(0, 99) < 40);
            rScV  = ($urandom_range(0, 99) < 30);
            rWrV  = ($urandom_range(0, 99) < 20);
            rRdy  = ($urandom_range(0, 99) < 60);
            rLrId = 4'($urandom_range(0, 5));
            rScId = 4'($urandom_range(0, 5));
            rLrA  = 64'h8000 + 64'($urandom_range(0, 5)) * 64'd8 + 64'($urandom_range(0, 7));
            rScA  = 64'h8000 + 64'($urandom_range(0, 5)) * 64'd8 + 64'($urandom_range(0, 7));
            rWrA  = 64'h8000 + 64'($urandom_range(0, 5)) * 64'd8 + 64'($urandom_range(0, 7));
            applyStimulus(rLrV, rLrId, rLrA, rScV, rScId, rScA, rWrV, rWrA, rRdy);
        end
        idleStep(1'b1);
        idleStep(1'b1);

        $display("[TB] reset during RESP");
        lrStep(4'd5, 64'h9000);
        scStep(4'd6, 64'h9000, 1'b0);
        checkOutput("tp7_in_resp", {63'd0, sc_resp_valid_o}, 64'd1);
        sc_valid_i = 1'b0;
        rst_ni     = 1'b0;
        #1;
        modelReset();
        checkOutput("tp7_rst_valid", {63'd0, sc_resp_valid_o}, 64'd0);
        checkOutput("tp7_rst_cnt", {61'd0, resv_cnt_o}, 64'd0);
        checkOutput("tp7_rst_ready", {63'd0, lr_ready_o}, 64'd1);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        lrStep(4'd7, 64'hA000);
        idleStep(1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
